// File: rtl/latch_bank_sequencer.sv
// Loader for latch-based config banks: assembles a WIDTH-bit word from 32-bit bus writes and
// sweeps one-hot latch enables (full chain or one row) with programmable setup/pulse timing.
module latch_bank_sequencer #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 64,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int AUTO_LOAD = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write_req,
  input  logic [5:0]       address,
  input  logic [31:0]      data_in,
  output logic [WIDTH-1:0] config_data,
  output logic [DEPTH-1:0] latch_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int NW     = (WIDTH + 31) / 32;
  localparam int LAST_W = WIDTH - 32 * (NW - 1);
  localparam int MAXC   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int PW     = $clog2(MAXC + 1);
  localparam int RW     = $clog2(DEPTH);

  localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_CYC - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYC - 1);
  localparam logic [RW-1:0] TOP_ROW    = RW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] config_q, config_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             single_q, single_d;
  logic [DEPTH-1:0] latch_en_q, latch_en_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // write_req is a single-cycle strobe with no back-pressure: every strobe is consumed on the
  // edge it is sampled, either acted on, silently dropped, or flagged through err.
  logic [3:0] word_idx;
  logic       aligned;
  logic       is_cmd;
  logic       is_data;
  logic       cmd_abort;
  logic       cmd_run;

  assign word_idx  = address[5:2];
  assign aligned   = (address[1:0] == 2'b00);
  assign is_cmd    = write_req && aligned && (word_idx == 4'hF);
  assign is_data   = write_req && aligned && (int'(word_idx) < NW);
  assign cmd_abort = is_cmd && data_in[31];
  assign cmd_run   = is_cmd && !data_in[31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      config_q   <= '0;
      row_q      <= '0;
      phase_q    <= '0;
      single_q   <= 1'b0;
      latch_en_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      config_q   <= config_d;
      row_q      <= row_d;
      phase_q    <= phase_d;
      single_q   <= single_d;
      latch_en_q <= latch_en_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    config_d = config_q;
    row_d    = row_q;
    phase_d  = phase_q;
    single_d = single_q;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_data) begin
          for (int k = 0; k < NW - 1; k++) begin
            if (word_idx == 4'(k)) config_d[32*k +: 32] = data_in;
          end
          if (int'(word_idx) == NW - 1) begin
            config_d[WIDTH-1 -: LAST_W] = data_in[LAST_W-1:0];
            if (AUTO_LOAD != 0) begin
              state_d  = S_SETUP;
              single_d = 1'b0;
              row_d    = TOP_ROW;
              phase_d  = '0;
            end
          end
        end else if (cmd_run) begin
          err_d = 1'b0;
          if (data_in[8] && (int'(data_in[4:0]) >= DEPTH)) begin
            err_d = 1'b1;
          end else begin
            state_d  = S_SETUP;
            single_d = data_in[8];
            row_d    = data_in[8] ? data_in[RW-1:0] : TOP_ROW;
            phase_d  = '0;
          end
        end
      end
      S_SETUP: begin
        if (phase_q == SETUP_LAST) begin
          state_d = S_PULSE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_PULSE: begin
        if (phase_q == PULSE_LAST) begin
          phase_d = '0;
          // Row 0 is the last one of a sweep, so the counter never steps below zero.
          if (single_q || (row_q == '0)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            row_d   = row_q - RW'(1);
            state_d = S_SETUP;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && (is_data || cmd_run)) err_d = 1'b1;
    // Abort beats everything, including a completion landing on the same edge.
    if (cmd_abort) begin
      state_d = S_IDLE;
      phase_d = '0;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    latch_en_d = '0;
    if (state_d == S_PULSE) latch_en_d = DEPTH'(1) << row_d;
    busy = (state_q != S_IDLE);
  end

  assign config_data = config_q;
  assign latch_en    = latch_en_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
